// File: rtl/uart_arb_pkg.sv
// +----------------------------------------------------------------------+
// | uart_arb_pkg : shared types for the UART transmit arbiter             |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SEND       = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } state_e;

    localparam logic [7:0] EOL_DEFAULT = 8'h0A;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// +----------------------------------------------------------------------+
// | rr_pick : combinational round-robin first-set-bit finder             |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_pick #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] eligible_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] winner_o,
    output logic         found_o
);

    int w_idx;

    // Scan from the farthest offset back to the pointer so the nearest hit wins.
    always_comb begin
        winner_o = '0;
        found_o  = 1'b0;
        w_idx    = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = (int'(ptr_i) + k) % N;
            if (eligible_i[w_idx]) begin
                found_o  = 1'b1;
                winner_o = W'(w_idx);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// +----------------------------------------------------------------------+
// | uart_tx_arbiter : round-robin, line-locked sharing of one UART TX    |
// | Optional idle-owner timeout release: define UART_ARB_TIMEOUT_EN.     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int          NREQ     = 2,
    parameter int          IDW      = (NREQ > 1) ? $clog2(NREQ) : 1,
    parameter logic [7:0]  EOL_CHAR = EOL_DEFAULT,
    parameter logic [19:0] TIMEOUT  = 20'd1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx_transmit,
    output logic [7:0]        tx_byte,
    input  logic              tx_busy,
`ifdef UART_ARB_TIMEOUT_EN
    output logic              timeout_evt,
`endif
    output logic [IDW-1:0]    grant_id,
    output logic              locked
);

    state_e           state_q, state_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic             locked_q, locked_d;

    logic [NREQ-1:0]  w_own_mask;
    logic [NREQ-1:0]  w_eligible;
    logic [IDW-1:0]   w_win;
    logic             w_found;
    logic             w_accept;
    logic [7:0]       w_win_byte;

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
        return (v == IDW'(NREQ - 1)) ? '0 : v + 1'b1;
    endfunction

    assign w_own_mask = NREQ'(1) << grant_q;
    assign w_eligible = locked_q ? (req_valid & w_own_mask) : req_valid;
    assign w_accept   = (state_q == IDLE) && w_found && !tx_busy && !rst;
    assign w_win_byte = req_data[{w_win, 3'b000} +: 8];

    rr_pick #(
        .N (NREQ),
        .W (IDW)
    ) u_pick (
        .eligible_i (w_eligible),
        .ptr_i      (ptr_q),
        .winner_o   (w_win),
        .found_o    (w_found)
    );

`ifdef UART_ARB_TIMEOUT_EN
    logic [19:0] cnt_q, cnt_d;
    logic        evt_q, evt_d;
    logic        w_to_run;
    logic        w_to_fire;

    assign w_to_run    = locked_q && (state_q == IDLE) && !req_valid[grant_q];
    assign w_to_fire   = w_to_run && (cnt_q == TIMEOUT - 20'd1);
    assign timeout_evt = evt_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (w_accept) state_d = SEND;
            SEND:       state_d = WAIT_START;
            WAIT_START: if (tx_busy)  state_d = WAIT_DONE;
            WAIT_DONE:  if (!tx_busy) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = '0;
        tx_transmit = 1'b0;
        if (w_accept) begin
            req_ready[w_win] = 1'b1;
        end
        if (state_q == SEND) begin
            tx_transmit = 1'b1;
        end
    end

    // The pointer only advances when a line ends, so a locked owner keeps priority.
    always_comb begin
        tx_byte_d = tx_byte_q;
        grant_d   = grant_q;
        locked_d  = locked_q;
        ptr_d     = ptr_q;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        evt_d     = 1'b0;
`endif
        if (w_accept) begin
            tx_byte_d = w_win_byte;
            grant_d   = w_win;
            if (w_win_byte == EOL_CHAR) begin
                locked_d = 1'b0;
                ptr_d    = wrap_inc(w_win);
            end else begin
                locked_d = 1'b1;
            end
`ifdef UART_ARB_TIMEOUT_EN
            cnt_d = '0;
        end else if (w_to_fire) begin
            locked_d = 1'b0;
            ptr_d    = wrap_inc(grant_q);
            cnt_d    = '0;
            evt_d    = 1'b1;
        end else if (w_to_run) begin
            cnt_d = cnt_q + 20'd1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_byte_q <= 8'h00;
            grant_q   <= '0;
            locked_q  <= 1'b0;
            ptr_q     <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            evt_q     <= 1'b0;
`endif
        end else begin
            tx_byte_q <= tx_byte_d;
            grant_q   <= grant_d;
            locked_q  <= locked_d;
            ptr_q     <= ptr_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            evt_q     <= evt_d;
`endif
        end
    end

    assign tx_byte  = tx_byte_q;
    assign grant_id = grant_q;
    assign locked   = locked_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_uart_tx_arbiter : scoreboard bench for uart_tx_arbiter (NREQ=4)   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int NREQ     = 4;
    localparam int BAUD_CYC = 52;
    localparam int FRAME    = 10 * BAUD_CYC;

    typedef struct {
        logic [3:0] ready;
        logic [7:0] data;
        logic [1:0] id;
        logic       lk;
        int         lat;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_transmit;
    logic [7:0]  tx_byte;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        locked;
`ifdef UART_ARB_TIMEOUT_EN
    logic        timeout_evt;
`endif

    logic        m_busy = 1'b0;
    logic        force_busy = 1'b0;
    int          m_cnt = 0;
    logic [7:0]  m_byte = 8'h00;
    int          cyc = 0;

    logic [7:0]  src_q[4][$];
    bit          took[4];
    rec_t        obs_q[$];
    rec_t        exp_q[$];
    logic [7:0]  rx_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    assign tx_busy = m_busy | force_busy;

    uart_tx_arbiter #(
        .NREQ     (NREQ),
        .EOL_CHAR (8'h0A),
        .TIMEOUT  (20'd100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_transmit (tx_transmit),
        .tx_byte     (tx_byte),
        .tx_busy     (tx_busy),
`ifdef UART_ARB_TIMEOUT_EN
        .timeout_evt (timeout_evt),
`endif
        .grant_id    (grant_id),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // UART model: busy from the strobe edge for one 10-bit frame.
    always @(posedge clk) begin
        if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_busy <= 1'b0;
                rx_q.push_back(m_byte);
            end
        end else if (tx_transmit) begin
            m_busy <= 1'b1;
            m_cnt  <= FRAME;
            m_byte <= tx_byte;
        end
    end

    // Requesters: hold valid until the byte is taken, then load the next one.
    initial begin
        req_valid = '0;
        req_data  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (took[i]) begin
                    req_valid[i] = 1'b0;
                    took[i] = 1'b0;
                end
                if (!req_valid[i] && src_q[i].size() > 0) begin
                    req_valid[i] = 1'b1;
                    req_data[8*i +: 8] = src_q[i].pop_front();
                end
            end
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) took[i] = 1'b1;
            end
        end
    end

    // Monitor: records each strobe with the ready pattern that preceded it.
    initial begin
        logic [3:0] last_ready;
        int         rdy_cyc;
        rec_t       r;
        last_ready = '0;
        rdy_cyc    = 0;
        forever begin
            @(negedge clk);
            #3;
            if (req_ready != 4'b0000) begin
                last_ready = req_ready;
                rdy_cyc    = cyc;
            end
            if (tx_transmit) begin
                r.ready = last_ready;
                r.data  = tx_byte;
                r.id    = grant_id;
                r.lk    = locked;
                r.lat   = cyc - rdy_cyc;
                obs_q.push_back(r);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic wait_obs(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (obs_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic [1:0] id, input logic lk);
        rec_t e;
        e.ready = 4'b0001 << id;
        e.data  = d;
        e.id    = id;
        e.lk    = lk;
        e.lat   = 1;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        for (int k = 0; k < 2000 && m_busy; k++) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            src_q[i].delete();
            took[i] = 1'b0;
        end
        req_valid = '0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        obs_q.delete();
        exp_q.delete();
        rx_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #3;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
        n_checks++; if (tx_transmit !== 1'b0) begin n_fail++; $display("FAIL reset_transmit: got %b expected 0", tx_transmit); end
        n_checks++; if (tx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_tx_byte: got %h expected 00", tx_byte); end
        n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b expected 0", locked); end
        do_reset();
    endtask

    task automatic test_single_byte();
        bit ok;
        rec_t o, e;
        do_reset();
        push_exp(8'h41, 2'd0, 1'b1);
        src_q[0].push_back(8'h41);
        wait_obs(1, 200, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL single_timeout: got no strobe, expected one");
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_checks++; if (o.ready !== e.ready) begin n_fail++; $display("FAIL single_ready: got %b expected %b", o.ready, e.ready); end
            n_checks++; if (o.lat !== 1) begin n_fail++; $display("FAIL single_latency: got %0d expected 1", o.lat); end
            n_checks++; if (o.data !== e.data) begin n_fail++; $display("FAIL single_byte: got %h expected %h", o.data, e.data); end
            n_checks++; if (o.lk !== e.lk) begin n_fail++; $display("FAIL single_locked: got %b expected %b", o.lk, e.lk); end
        end
        for (int k = 0; k < FRAME + 100 && rx_q.size() == 0; k++) @(negedge clk);
        n_checks++;
        if (rx_q.size() == 0) begin
            n_fail++; $display("FAIL single_rx: got nothing expected 41");
        end else if (rx_q[0] !== 8'h41) begin
            n_fail++; $display("FAIL single_rx: got %h expected 41", rx_q[0]);
        end
    endtask

    task automatic test_line_lock();
        bit ok;
        rec_t o, e;
        do_reset();
        push_exp(8'h41, 2'd0, 1'b1);
        push_exp(8'h42, 2'd0, 1'b1);
        push_exp(8'h0A, 2'd0, 1'b0);
        push_exp(8'h78, 2'd1, 1'b1);
        src_q[0].push_back(8'h41);
        src_q[0].push_back(8'h42);
        src_q[0].push_back(8'h0A);
        wait_obs(1, 200, ok);
        src_q[1].push_back(8'h78);
        wait_obs(4, 4 * (FRAME + 50), ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL lock_timeout: got %0d strobes expected 4", obs_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                n_checks++; if (o.data !== e.data) begin n_fail++; $display("FAIL lock_data[%0d]: got %h expected %h", k, o.data, e.data); end
                n_checks++; if (o.id !== e.id) begin n_fail++; $display("FAIL lock_grant[%0d]: got %0d expected %0d", k, o.id, e.id); end
                n_checks++; if (o.lk !== e.lk) begin n_fail++; $display("FAIL lock_locked[%0d]: got %b expected %b", k, o.lk, e.lk); end
            end
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        rec_t o, e;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            push_exp(8'h0A, 2'(i), 1'b0);
            src_q[i].push_back(8'h0A);
        end
        push_exp(8'h0A, 2'd0, 1'b0);
        src_q[0].push_back(8'h0A);
        wait_obs(5, 5 * (FRAME + 50), ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL rr_timeout: got %0d strobes expected 5", obs_q.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                n_checks++; if (o.id !== e.id) begin n_fail++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", k, o.id, e.id); end
                n_checks++; if (o.ready !== e.ready) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, o.ready, e.ready); end
            end
        end
    endtask

    task automatic test_busy_gating();
        bit ok;
        int bad;
        rec_t o, e;
        force_busy = 1'b1;
        do_reset();
        push_exp(8'h55, 2'd0, 1'b1);
        src_q[0].push_back(8'h55);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            #3;
            if (req_ready != 4'b0000) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL busy_stall: got %0d ready cycles expected 0", bad); end
        @(negedge clk);
        force_busy = 1'b0;
        #2;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL busy_release_ready: got %b expected 0001", req_ready); end
        wait_obs(1, 50, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL busy_timeout: got no strobe expected one");
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_checks++; if (o.data !== e.data) begin n_fail++; $display("FAIL busy_byte: got %h expected %h", o.data, e.data); end
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        rec_t o, e;
        do_reset();
        src_q[0].push_back(8'h41);
        for (int k = 0; k < 200 && !m_busy; k++) @(negedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_ready: got %b expected 0000", req_ready); end
        n_checks++; if (tx_transmit !== 1'b0) begin n_fail++; $display("FAIL mid_transmit: got %b expected 0", tx_transmit); end
        n_checks++; if (tx_byte !== 8'h00) begin n_fail++; $display("FAIL mid_tx_byte: got %h expected 00", tx_byte); end
        n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL mid_grant: got %0d expected 0", grant_id); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL mid_locked: got %b expected 0", locked); end
        @(posedge clk);
        #2;
        rst = 1'b0;
        obs_q.delete();
        push_exp(8'h79, 2'd1, 1'b1);
        src_q[1].push_back(8'h79);
        wait_obs(1, FRAME + 200, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL mid_after_timeout: got no strobe expected one");
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_checks++; if (o.id !== e.id) begin n_fail++; $display("FAIL mid_after_grant: got %0d expected %0d", o.id, e.id); end
            n_checks++; if (o.data !== e.data) begin n_fail++; $display("FAIL mid_after_byte: got %h expected %h", o.data, e.data); end
        end
    endtask

`ifdef UART_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int t0, t1;
        rec_t o, e;
        do_reset();
        push_exp(8'h41, 2'd0, 1'b1);
        src_q[0].push_back(8'h41);
        wait_obs(1, 200, ok);
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        src_q[1].push_back(8'h78);
        push_exp(8'h78, 2'd1, 1'b1);
        for (int k = 0; k < 50 && !m_busy; k++) @(negedge clk);
        for (int k = 0; k < FRAME + 50 && m_busy; k++) @(negedge clk);
        t0 = cyc;
        t1 = -1;
        for (int k = 0; k < 400; k++) begin
            #3;
            if (timeout_evt) begin
                t1 = cyc;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (t1 < 0) begin
            n_fail++; $display("FAIL timeout_evt: got no pulse expected one");
        end else if ((t1 - t0) < 99 || (t1 - t0) > 102) begin
            n_fail++; $display("FAIL timeout_delay: got %0d cycles expected about 100", t1 - t0);
        end
        wait_obs(1, 100, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL timeout_next: got no strobe expected one");
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_checks++; if (o.id !== e.id) begin n_fail++; $display("FAIL timeout_grant: got %0d expected %0d", o.id, e.id); end
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        test_reset();
        test_single_byte();
        test_line_lock();
        test_round_robin();
        test_busy_gating();
        test_reset_midframe();
`ifdef UART_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single board UART transmitter (byte-wide transmit/tx_byte/is_transmitting interface) between NREQ on-chip byte sources, e.g. the CPU console and a debug/boot monitor. Round-robin arbitration with line locking: once a requester wins, it owns the UART until it sends EOL_CHAR, so console lines never interleave. It sits between the requesters and the uart instance, and drives that instance's transmit and tx_byte inputs.

Parameters:
NREQ, 2, number of requesters (2..8)
IDW, $clog2(NREQ) (min 1), width of grant_id
EOL_CHAR, 8'h0A, byte that releases the line lock
TIMEOUT, 20'd1000000, idle-owner cycles before forced release (used only with UART_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  NREQ  requester i has a byte pending; held until req_ready[i]
req_data  in  8*NREQ  byte of requester i at bits [8i+7:8i]
req_ready  out  NREQ  one-hot pulse; byte of requester i accepted this cycle
tx_transmit  out  1  one-cycle transmit strobe to uart
tx_byte  out  8  byte to uart, registered, stable from strobe until frame done
tx_busy  in  1  uart is_transmitting
grant_id  out  IDW  current/last owner index
locked  out  1  an owner holds the line lock

Behaviour:
- Reset values: req_ready=0, tx_transmit=0, tx_byte=8'h00, grant_id=0, locked=0, RR pointer=0, state=IDLE, timeout counter=0.
- FSM states: IDLE, SEND, WAIT_START, WAIT_DONE.
- IDLE: eligible set = req_valid masked to owner only if locked, else all requesters. If the set is non-empty and tx_busy=0: pick winner w (locked: owner; else first set bit scanning from RR pointer upward with wrap-around). Assert req_ready[w] combinationally in the same cycle. Register tx_byte<=req_data[w] and grant_id<=w. Go to SEND.
- Lock update on accept: if byte==EOL_CHAR, then locked<=0 and pointer<=(w+1) mod NREQ. Otherwise locked<=1. The pointer does not move while locked.
- SEND: tx_transmit=1 for exactly one cycle. Go to WAIT_START.
- WAIT_START: wait for tx_busy=1, then go to WAIT_DONE.
- WAIT_DONE: wait for tx_busy=0, then go to IDLE.
- Latency: accept at cycle t, strobe at t+1. The next accept comes no earlier than 1 cycle after tx_busy falls.
- Locked and owner not valid: other requesters stall, even if valid. Without the optional feature, the lock is held indefinitely.
- tx_busy=1 while in IDLE (e.g. after reset): no accept until it drops.
- Simultaneous valid from all requesters when unlocked: pointer decides. Exactly one req_ready bit is high per cycle.
- req_valid dropping before ready: the byte is discarded without error; requesters must not do this.
- Reset mid-frame: FSM returns to IDLE and all outputs take reset values. Nothing already handed to the uart is aborted by this block.
- Invariant: req_ready is only asserted in IDLE.

Optional Feature:
Macro UART_ARB_TIMEOUT_EN.
- Defined: a 20-bit counter runs while locked=1 and state=IDLE and req_valid[owner]=0. It clears on any accept. When it reaches TIMEOUT-1, locked<=0 and pointer<=owner+1 on the next edge. An extra output timeout_evt (1 bit) pulses one cycle at the forced release.
- Undefined: no counter, no timeout_evt port, the lock is released only by EOL_CHAR.

Decomposition:
- Package uart_arb_pkg: the FSM state enum (IDLE, SEND, WAIT_START, WAIT_DONE) and localparam EOL_DEFAULT=8'h0A.
- One sub-module rr_pick: a combinational round-robin first-set-bit finder. Inputs: eligible mask and pointer. Outputs: winner index and found flag. Reused elsewhere for other shared peripherals.

Test Plan:
- Single byte: req0 sends 8'h41. Required: req_ready[0] pulses in the accept cycle, tx_transmit strobes the next cycle with tx_byte=8'h41, locked=1, and a 52-cycle-baud uart model receives 'A'.
- Line lock: req0 sends "AB\n" and req1 raises valid with 'x' during 'A'. Required: the order is A,B,0x0A,x; locked falls after 0x0A; grant_id goes 0,0,0,1.
- Round-robin fairness: NREQ=4, all requesters valid, each sending single-byte lines of 0x0A. Required: grant order 0,1,2,3,0 and exactly one req_ready bit per accept.
- Busy gating: force tx_busy=1 after reset with req0 valid. Required: no req_ready until tx_busy=0, then accept one cycle later.
- Reset mid-frame: assert rst during WAIT_DONE. Required: all outputs take reset values the next cycle; after release, req1 wins first (pointer=0, only req1 valid).
- Timeout (with UART_ARB_TIMEOUT_EN, TIMEOUT=100): req0 sends 'A' then idles while req1 is valid. Required: timeout_evt pulses 100 cycles after the 'A' frame completes, then req1 is accepted.
